// File: rtl/mc_core.sv
// mc_core -- small multi-cycle accumulator core.
//
// Fetches 9-bit instructions from an external ROM. Each instruction takes
// FETCH + EXEC, and LD/ST add a MEM phase that waits for dmem_ack.
// There are eight DW-bit registers (r0 is the accumulator) plus the Z and C flags.
//
// Ports:
//   CLK         clock, all state changes on posedge
//   start       asynchronous active-high reset; execution starts at PC=0
//   inst_addr   instruction ROM address (= PC)
//   inst_in     instruction word for inst_addr (combinational)
//   dmem_req    data-memory request, high only in MEM
//   dmem_we     write qualifier (ST)
//   dmem_addr   data address (= rs register)
//   dmem_wdata  store data (= r0)
//   dmem_rdata  load data, valid with dmem_ack
//   dmem_ack    transfer complete
//   halt        program done
//   cycle_ct    executed-cycle counter, saturating
module mc_core #(
    parameter int DW  = 8,
    parameter int PCW = 10
) (
    input  logic           CLK,
    input  logic           start,
    output logic [PCW-1:0] inst_addr,
    input  logic [8:0]     inst_in,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    input  logic [DW-1:0]  dmem_rdata,
    input  logic           dmem_ack,
    output logic           halt,
    output logic [15:0]    cycle_ct
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] fn;
        logic [2:0] rs;
    } inst_t;

    localparam logic [2:0] OP_ALU = 3'd0, OP_MVT = 3'd1, OP_MVF = 3'd2, OP_LDI = 3'd3,
                           OP_LD  = 3'd4, OP_ST  = 3'd5, OP_BZ  = 3'd6, OP_JMP = 3'd7;

    state_t              state, state_nx;
    logic [PCW-1:0]      pc, pc_nx;
    inst_t               ir;
    logic [7:0][DW-1:0]  rf;
    logic                z, c, z_nx, c_nx;
    logic                r0_we, rs_we;
    logic [DW-1:0]       r0_nx;

    logic [DW-1:0]       r0, rsv;
    logic [5:0]          imm6;
    logic signed [5:0]   imm_s;
    logic [PCW-1:0]      br_off;

    assign r0     = rf[0];
    assign rsv    = rf[ir.rs];
    assign imm6   = {ir.fn, ir.rs};
    assign imm_s  = imm6;
    assign br_off = PCW'(imm_s);   // sign-extend the branch offset

    // ALU
    logic [DW:0]   alu_sum;
    logic [DW-1:0] alu_res;
    logic          alu_c;

    always_comb begin
        alu_sum = '0;
        alu_res = r0;
        alu_c   = c;
        case (ir.fn)
            3'd0: alu_sum = {1'b0, r0} + {1'b0, rsv};
            3'd1: alu_sum = {1'b0, r0} + {1'b0, rsv} + (DW+1)'(c);
            3'd2: alu_sum = {1'b0, r0} + {1'b0, ~rsv} + (DW+1)'(1);  // C=1 means no borrow
            3'd3: alu_res = r0 & rsv;
            3'd4: alu_res = r0 | rsv;
            3'd5: alu_res = r0 ^ rsv;
            3'd6: {alu_c, alu_res} = {r0, 1'b0};
            default: begin
                alu_res = {1'b0, r0[DW-1:1]};
                alu_c   = r0[0];
            end
        endcase
        if (ir.fn <= 3'd2) begin
            alu_res = alu_sum[DW-1:0];
            alu_c   = alu_sum[DW];
        end
    end

    // Next state / commit control
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        r0_we    = 1'b0;
        r0_nx    = r0;
        rs_we    = 1'b0;
        c_nx     = c;
        case (state)
            FETCH: state_nx = EXEC;
            EXEC: begin
                state_nx = FETCH;
                pc_nx    = pc + PCW'(1);
                case (ir.op)
                    OP_ALU: begin
                        r0_we = 1'b1;
                        r0_nx = alu_res;
                        c_nx  = alu_c;
                    end
                    OP_MVT: rs_we = 1'b1;
                    OP_MVF: begin
                        r0_we = 1'b1;
                        r0_nx = rsv;
                    end
                    OP_LDI: begin
                        r0_we = 1'b1;
                        r0_nx = DW'(imm6);
                    end
                    OP_LD, OP_ST: begin
                        state_nx = MEM;
                        pc_nx    = pc;   // advanced when the transfer completes
                    end
                    OP_BZ: if (z) pc_nx = pc + br_off;
                    default: begin
                        if (imm6 == 6'd0) begin
                            state_nx = HALTED;
                            pc_nx    = pc;
                        end else begin
                            pc_nx = pc + br_off;
                        end
                    end
                endcase
            end
            MEM: begin
                if (dmem_ack) begin
                    state_nx = FETCH;
                    pc_nx    = pc + PCW'(1);
                    if (ir.op == OP_LD) begin
                        r0_we = 1'b1;
                        r0_nx = dmem_rdata;
                    end
                end
            end
            default: ;  // HALTED: everything frozen
        endcase
        z_nx = r0_we ? (r0_nx == '0) : z;
    end

    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            rf    <= '0;
            z     <= 1'b1;
            c     <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            z     <= z_nx;
            c     <= c_nx;
            if (state == FETCH) ir <= inst_t'(inst_in);
            if (rs_we) rf[ir.rs] <= r0;
            if (r0_we) rf[0]     <= r0_nx;
        end
    end

    always_ff @(posedge CLK or posedge start) begin
        if (start)                                  cycle_ct <= '0;
        else if (!halt && cycle_ct != 16'hFFFF)     cycle_ct <= cycle_ct + 16'd1;
    end

    // The request decodes straight from state, so an asynchronous reset
    // drops it in the same cycle and abandons the transfer.
    assign inst_addr  = pc;
    assign dmem_req   = (state == MEM);
    assign dmem_we    = (state == MEM) && (ir.op == OP_ST);
    assign dmem_addr  = rsv;
    assign dmem_wdata = r0;
    assign halt       = (state == HALTED);

endmodule

// File: tb/tb_mc_core.sv
// Testbench for mc_core: ROM model, data-memory responder with programmable
// ack latency, and a store scoreboard (expected stores queued per program,
// popped as the core completes each ST).
module tb_mc_core;

    localparam int DW  = 8;
    localparam int PCW = 10;

    logic           CLK = 1'b0;
    logic           start;
    logic [PCW-1:0] inst_addr;
    logic [8:0]     inst_in;
    logic           dmem_req, dmem_we;
    logic [DW-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic           dmem_ack;
    logic           halt;
    logic [15:0]    cycle_ct;

    mc_core #(.DW(DW), .PCW(PCW)) dut (
        .CLK(CLK), .start(start), .inst_addr(inst_addr), .inst_in(inst_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .halt(halt), .cycle_ct(cycle_ct)
    );

    always #5 CLK = ~CLK;

    logic [8:0]    rom [1024];
    logic [DW-1:0] mem [256];
    assign inst_in = rom[inst_addr];

    typedef struct { logic [7:0] addr; logic [7:0] data; } st_t;
    st_t sb[$];

    int n_vec = 0, n_err = 0;
    int ack_dly = 0;
    int req_cycles = 0;
    int inj_req = 0, inj_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] fn, input logic [2:0] rs);
        return {op, fn, rs};
    endfunction

    function automatic logic [8:0] insi(input logic [2:0] op, input logic [5:0] imm);
        return {op, imm};
    endfunction

    task automatic exp_st(input logic [7:0] a, input logic [7:0] d);
        st_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 1024; i++) rom[i] = 9'b111_000000;  // HALT
    endtask

    // Data-memory responder, acts on negedges.
    initial begin
        int wait_ct;
        logic [DW-1:0] txn_addr;
        st_t e;
        wait_ct    = 0;
        txn_addr   = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge CLK);
            dmem_ack = 1'b0;
            if (dmem_req) begin
                if (wait_ct == 0) txn_addr = dmem_addr;
                else chk("addr_stable", 32'(dmem_addr), 32'(txn_addr));
                req_cycles = wait_ct + 1;
                if (wait_ct >= ack_dly) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) begin
                        mem[dmem_addr] = dmem_wdata;
                        if (sb.size() == 0) begin
                            chk("unexpected_store", 32'(dmem_addr), 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            chk("st_addr", 32'(dmem_addr), 32'(e.addr));
                            chk("st_data", 32'(dmem_wdata), 32'(e.data));
                        end
                    end else begin
                        dmem_rdata = mem[dmem_addr];
                    end
                    wait_ct = 0;
                end else begin
                    wait_ct++;
                end
            end else begin
                wait_ct = 0;
                if (inj_req != inj_done) begin
                    dmem_ack   = 1'b1;       // stray ack outside MEM
                    dmem_rdata = 8'h77;
                    inj_done   = inj_req;
                end
            end
        end
    end

    task automatic release_rst();
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic reset_chk(input string tag);
        @(negedge CLK);
        start = 1'b1;
        #1;
        chk({tag, "_halt"},  32'(halt), 0);
        chk({tag, "_ct"},    32'(cycle_ct), 0);
        chk({tag, "_pc"},    32'(inst_addr), 0);
        chk({tag, "_req"},   32'(dmem_req), 0);
        chk({tag, "_we"},    32'(dmem_we), 0);
    endtask

    task automatic wait_halt(input int budget, input logic [PCW-1:0] exp_pc, input logic [15:0] exp_ct);
        for (int i = 0; i < budget && !halt; i++) @(negedge CLK);
        chk("halt_reached", 32'(halt), 1);
        chk("halt_pc", 32'(inst_addr), 32'(exp_pc));
        chk("halt_ct", 32'(cycle_ct), 32'(exp_ct));
        repeat (4) @(negedge CLK);
        chk("frozen_pc", 32'(inst_addr), 32'(exp_pc));
        chk("frozen_ct", 32'(cycle_ct), 32'(exp_ct));
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        start = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rom_clear();
        #1;
        chk("rst_halt", 32'(halt), 0);
        chk("rst_ct",   32'(cycle_ct), 0);
        chk("rst_pc",   32'(inst_addr), 0);
        chk("rst_req",  32'(dmem_req), 0);
        chk("rst_we",   32'(dmem_we), 0);

        // P1: arithmetic, Z/C after ADD, cycle counter
        rom[0]  = insi(3'd3, 6'd5);          // LDI 5
        rom[1]  = ins(3'd1, 3'd0, 3'd1);     // r1 <= r0
        rom[2]  = insi(3'd3, 6'd3);          // LDI 3
        rom[3]  = ins(3'd0, 3'd0, 3'd1);     // ADD r1 -> 8
        rom[4]  = ins(3'd5, 3'd0, 3'd1);     // ST [r1=5] <= 8
        rom[5]  = insi(3'd6, 6'd2);          // BZ +2 (Z=0, not taken)
        rom[6]  = insi(3'd3, 6'h11);         // LDI 0x11
        rom[7]  = ins(3'd5, 3'd0, 3'd1);     // ST [5] <= 0x11
        rom[8]  = ins(3'd0, 3'd1, 3'd7);     // ADDC r7 (C=0) -> 0x11
        rom[9]  = ins(3'd5, 3'd0, 3'd1);     // ST [5] <= 0x11
        exp_st(8'd5, 8'd8);
        exp_st(8'd5, 8'h11);
        exp_st(8'd5, 8'h11);
        ack_dly = 0;
        release_rst();
        repeat (8) @(posedge CLK);
        #1 chk("p1_ct_after_4_exec", 32'(cycle_ct), 8);
        wait_halt(100, 10'd10, 16'd25);

        // P2: borrow and carry chain
        reset_chk("p2_rst");
        rom_clear();
        rom[0]  = insi(3'd3, 6'd1);          // LDI 1
        rom[1]  = ins(3'd1, 3'd0, 3'd1);     // r1 <= 1
        rom[2]  = insi(3'd3, 6'd0);          // LDI 0
        rom[3]  = ins(3'd0, 3'd2, 3'd1);     // SUB r1 -> FF, C=0, Z=0
        rom[4]  = ins(3'd1, 3'd0, 3'd3);     // r3 <= FF
        rom[5]  = ins(3'd5, 3'd0, 3'd2);     // ST [0] <= FF
        rom[6]  = insi(3'd6, 6'd2);          // BZ +2 (not taken)
        rom[7]  = insi(3'd3, 6'h22);         // LDI 0x22
        rom[8]  = ins(3'd5, 3'd0, 3'd2);     // ST [0] <= 22
        rom[9]  = ins(3'd2, 3'd0, 3'd3);     // r0 <= FF
        rom[10] = ins(3'd0, 3'd1, 3'd1);     // ADDC r1 -> 00, C=1, Z=1
        rom[11] = insi(3'd6, 6'd2);          // BZ +2 (taken -> 13)
        rom[12] = insi(3'd3, 6'h33);         // skipped
        rom[13] = ins(3'd5, 3'd0, 3'd2);     // ST [0] <= 00
        rom[14] = ins(3'd0, 3'd1, 3'd7);     // ADDC r7 -> 01
        rom[15] = ins(3'd5, 3'd0, 3'd2);     // ST [0] <= 01
        exp_st(8'd0, 8'hFF);
        exp_st(8'd0, 8'h22);
        exp_st(8'd0, 8'h00);
        exp_st(8'd0, 8'h01);
        release_rst();
        wait_halt(100, 10'd16, 16'd36);

        // P3: load with a 3-cycle ack wait
        reset_chk("p3_rst");
        rom_clear();
        mem[8'h10] = 8'hA5;
        rom[0]  = insi(3'd3, 6'h10);         // LDI 0x10
        rom[1]  = ins(3'd1, 3'd0, 3'd2);     // r2 <= 0x10
        rom[2]  = ins(3'd4, 3'd0, 3'd2);     // LD [r2] -> A5
        rom[3]  = insi(3'd6, 6'd2);          // BZ +2 (not taken, Z=0)
        rom[4]  = ins(3'd5, 3'd0, 3'd2);     // ST [0x10] <= A5
        exp_st(8'h10, 8'hA5);
        ack_dly = 3;
        release_rst();
        for (int i = 0; i < 50 && !dmem_req; i++) @(negedge CLK);
        chk("p3_ld_addr", 32'(dmem_addr), 32'h10);
        chk("p3_ld_we",   32'(dmem_we), 0);
        @(posedge dmem_ack);
        @(negedge CLK);
        chk("p3_ld_req_cycles", 32'(req_cycles), 4);
        wait_halt(100, 10'd5, 16'd20);
        chk("p3_st_req_cycles", 32'(req_cycles), 4);

        // P4: backwards branch wraps the PC, then halt and reset out of HALTED
        reset_chk("p4_rst");
        rom_clear();
        rom[0]  = insi(3'd6, 6'h3F);         // BZ -1 with Z=1 after reset
        ack_dly = 0;
        release_rst();
        repeat (2) @(posedge CLK);
        #1 chk("p4_wrap_pc", 32'(inst_addr), 32'h3FF);
        wait_halt(20, 10'h3FF, 16'd4);
        reset_chk("p4_halt_rst");

        // P5: reset in the middle of a load, stray ack afterwards
        rom_clear();
        rom[0]  = ins(3'd4, 3'd0, 3'd0);     // LD [r0]
        ack_dly = 1000;
        release_rst();
        for (int i = 0; i < 50 && !dmem_req; i++) @(negedge CLK);
        chk("p5_req_up", 32'(dmem_req), 1);
        @(negedge CLK);
        start = 1'b1;
        #1;
        chk("p5_req_drop", 32'(dmem_req), 0);
        chk("p5_pc",       32'(inst_addr), 0);
        rom_clear();
        rom[0]  = ins(3'd5, 3'd0, 3'd0);     // ST [r0=0] <= 0 (LD must not have landed)
        rom[1]  = insi(3'd6, 6'd2);          // BZ +2 (Z=1 -> 3)
        exp_st(8'd0, 8'd0);
        ack_dly = 0;
        @(posedge CLK);
        inj_req++;
        @(negedge CLK);
        start = 1'b0;
        wait_halt(50, 10'd3, 16'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
